// File: rtl/lockreg_access_ctrl_pkg.sv
// Shared types and constants for the lock-protected register bank.
//   state_e      : access FSM states (IDLE -> EXEC -> RESP)
//   VIOL_CNT_W   : width of the rejected-write counter
//   VIOL_CNT_MAX : saturation value of that counter
//   idx_w()      : index width for a vector of n entries (minimum 1)
package lockreg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned VIOL_CNT_W = 8;
    localparam logic [VIOL_CNT_W-1:0] VIOL_CNT_MAX = '1;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lockreg_access_ctrl_if.sv
// Request/response bus between the requesters and the register bank.
//   req_valid/req_write/req_lock : per-requester command bits
//   req_addr/req_wdata           : packed per-requester address and data
//   req_ready                    : one-hot accept
//   rsp_valid/rsp_rdata/rsp_err  : one-hot response strobe with shared payload
// master = requester side, slave = register bank side.
interface lockreg_access_ctrl_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;

    modport master (
        output req_valid, req_write, req_lock, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_lock, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lockreg_access_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after i_ptr wins.
//   i_req   : request vector
//   i_ptr   : highest-priority index
//   o_gnt_c : one-hot grant
//   o_idx_c : index of the granted requester
//   o_any_c : at least one request present
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt_c,
    output logic [IDX_W-1:0]   o_idx_c,
    output logic               o_any_c
);

    logic [IDX_W-1:0] w_j;

    // Scan the requesters in rotated order, keep the first hit.
    always_comb begin
        o_gnt_c = '0;
        o_idx_c = '0;
        o_any_c = 1'b0;
        w_j     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_j = IDX_W'((32'(i_ptr) + i) % NUM_REQ);
            if (!o_any_c && i_req[w_j]) begin
                o_any_c      = 1'b1;
                o_gnt_c[w_j] = 1'b1;
                o_idx_c      = w_j;
            end
        end
    end

endmodule

// File: rtl/lockreg_access_ctrl.sv
// Arbitrated access to a bank of sticky-lock protected config registers.
// Rejected writes raise rsp_err, pulse viol_pulse and bump a saturating counter.
// Ports:
//   clk, resetn    : clock, async active-low reset
//   bus (slave)    : request/response bus from the requesters
//   scan_mode      : blocks all writes and hides locked registers from reads
//   debug_unlocked : observed only; never relaxes a lock
//   lock_status    : current lock bits
//   reg_q          : packed register contents
//   viol_pulse     : one-cycle strobe during EXEC of a rejected write
//   viol_count     : saturating rejected-write count
// Build option: LOCKREG_SCAN_CLEAR_EN clears register data (not locks) on a
// scan_mode rising edge.
module lockreg_access_ctrl
    import lockreg_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned DATA_W   = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    lockreg_access_ctrl_if.slave       bus,
    input  logic                       scan_mode,
    input  logic                       debug_unlocked,
    output logic [NUM_REGS-1:0]        lock_status,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic                       viol_pulse,
    output logic [VIOL_CNT_W-1:0]      viol_count
);

    localparam int unsigned ADDR_W = $clog2(NUM_REGS);
    localparam int unsigned IDX_W  = idx_w(NUM_REQ);

    state_e              r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_ptr;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic                w_any;
    logic [NUM_REQ-1:0]  w_ready;
    logic                w_viol_pulse;

    logic [IDX_W-1:0]    r_idx;
    logic                r_write;
    logic                r_lock;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_locks;
    logic [VIOL_CNT_W-1:0] r_viol_cnt;

    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    logic                w_addr_ok, w_locked, w_wr_ok, w_viol, w_rd_hidden, w_err;
    logic [DATA_W-1:0]   w_rdata;

    // Debug state is deliberately excluded from every access decision.
    logic w_unused_debug;
    assign w_unused_debug = debug_unlocked;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_gnt_c (w_gnt),
        .o_idx_c (w_gnt_idx),
        .o_any_c (w_any)
    );

    // Access decision on the captured command.
    assign w_addr_ok   = (32'(r_addr) < NUM_REGS);
    assign w_locked    = w_addr_ok && r_locks[r_addr];
    assign w_wr_ok     = w_addr_ok && !w_locked && !scan_mode;
    assign w_viol      = r_write && w_addr_ok && !w_wr_ok;
    assign w_rd_hidden = scan_mode && w_locked;
    assign w_err       = !w_addr_ok || (r_write ? !w_wr_ok : w_rd_hidden);
    assign w_rdata     = (!r_write && w_addr_ok && !w_rd_hidden) ? r_regs[r_addr] : '0;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next state; accept and violation strobes are decoded from state.
    always_comb begin
        w_state_nxt  = r_state;
        w_ready      = '0;
        w_viol_pulse = 1'b0;
        case (r_state)
            IDLE: if (w_any) begin
                w_ready     = w_gnt;
                w_state_nxt = EXEC;
            end
            EXEC: begin
                w_viol_pulse = w_viol;
                w_state_nxt  = RESP;
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef LOCKREG_SCAN_CLEAR_EN
    logic r_scan_d;
    logic w_scan_clr;
    assign w_scan_clr = scan_mode && !r_scan_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_scan_d <= 1'b0;
        else         r_scan_d <= scan_mode;
    end
`else
    logic w_scan_clr;
    assign w_scan_clr = 1'b0;
`endif

    // Command capture, register/lock/counter update, response and pointer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ptr       <= '0;
            r_idx       <= '0;
            r_write     <= 1'b0;
            r_lock      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_locks     <= '0;
            r_viol_cnt  <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                IDLE: if (w_any) begin
                    r_idx   <= w_gnt_idx;
                    r_write <= bus.req_write[w_gnt_idx];
                    r_lock  <= bus.req_lock[w_gnt_idx];
                    r_addr  <= bus.req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
                    r_wdata <= bus.req_wdata[w_gnt_idx*DATA_W +: DATA_W];
                end
                EXEC: begin
                    if (r_write && w_wr_ok) begin
                        r_regs[r_addr] <= r_wdata;
                        if (r_lock) r_locks[r_addr] <= 1'b1;
                    end
                    if (w_viol && (r_viol_cnt != VIOL_CNT_MAX))
                        r_viol_cnt <= r_viol_cnt + VIOL_CNT_W'(1);
                    r_rsp_valid <= NUM_REQ'(1) << r_idx;
                    r_rsp_rdata <= w_rdata;
                    r_rsp_err   <= w_err;
                end
                RESP: r_ptr <= (32'(r_idx) == NUM_REQ - 1) ? '0 : r_idx + IDX_W'(1);
                default: ;
            endcase
            // Scan-entry clear wins over a same-cycle write; locks survive.
            if (w_scan_clr) begin
                for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign viol_pulse    = w_viol_pulse;
    assign viol_count    = r_viol_cnt;
    assign lock_status   = r_locks;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
        assign reg_q[g*DATA_W +: DATA_W] = r_regs[g];
    end

endmodule

// File: tb/tb_lockreg_access_ctrl.sv
// Directed self-checking bench for lockreg_access_ctrl.
module tb_lockreg_access_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        scan_mode = 1'b0;
    logic        debug_unlocked = 1'b0;
    logic [3:0]  lock_status;
    logic [63:0] reg_q;
    logic        viol_pulse;
    logic [7:0]  viol_count;

    int n_assert = 0;
    int n_fail   = 0;

    lockreg_access_ctrl_if #(.NUM_REQ(2), .ADDR_W(2), .DATA_W(16)) bus ();

    lockreg_access_ctrl #(.NUM_REQ(2), .NUM_REGS(4), .DATA_W(16)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .bus            (bus),
        .scan_mode      (scan_mode),
        .debug_unlocked (debug_unlocked),
        .lock_status    (lock_status),
        .reg_q          (reg_q),
        .viol_pulse     (viol_pulse),
        .viol_count     (viol_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input bit wr, input bit lk, input logic [1:0] a, input logic [15:0] d);
        bus.req_valid[r] = 1'b1;
        bus.req_write[r] = wr;
        bus.req_lock[r]  = lk;
        bus.req_addr[r*2 +: 2]   = a;
        bus.req_wdata[r*16 +: 16] = d;
    endtask

    // One single-requester access; returns at the negedge of the response cycle.
    task automatic access(input string tag, input int r, input bit wr, input bit lk,
                          input logic [1:0] a, input logic [15:0] d,
                          input bit e_err, input logic [15:0] e_rd, input bit e_viol);
        int t;
        logic [1:0] onehot;
        onehot = 2'b01 << r;
        @(negedge clk);
        set_req(r, wr, lk, a, d);
        #1;
        t = 0;
        while (bus.req_ready == 2'b00 && t < 20) begin
            @(negedge clk); #1; t++;
        end
        chk({tag, " ready"}, 64'(bus.req_ready), 64'(onehot));
        @(negedge clk);
        bus.req_valid[r] = 1'b0;
        chk({tag, " exec_rsp"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, " viol_pulse"}, 64'(viol_pulse), 64'(e_viol));
        @(negedge clk);
        chk({tag, " rsp_valid"}, 64'(bus.rsp_valid), 64'(onehot));
        chk({tag, " rsp_err"}, 64'(bus.rsp_err), 64'(e_err));
        chk({tag, " rsp_rdata"}, 64'(bus.rsp_rdata), 64'(e_rd));
    endtask

    initial begin
        int t;
        int cnt;
        int cyc;
        logic [1:0] exp_g;
        logic [15:0] exp_rd;

        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst lock_status", 64'(lock_status), 64'd0);
        chk("rst reg_q", reg_q, 64'd0);
        chk("rst viol_count", 64'(viol_count), 64'd0);
        chk("rst rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst req_ready", 64'(bus.req_ready), 64'd0);
        resetn = 1'b1;

        // 1: plain write then read back
        access("t1 wr", 0, 1'b1, 1'b0, 2'd1, 16'hA5A5, 1'b0, 16'h0000, 1'b0);
        chk("t1 reg1", 64'(reg_q[31:16]), 64'hA5A5);
        access("t1 rd", 1, 1'b0, 1'b0, 2'd1, 16'h0000, 1'b0, 16'hA5A5, 1'b0);

        // 2: lock-write, then rejected overwrite by another requester
        access("t2 lkwr", 0, 1'b1, 1'b1, 2'd2, 16'h1234, 1'b0, 16'h0000, 1'b0);
        chk("t2 lock", 64'(lock_status), 64'h4);
        access("t2 rej", 1, 1'b1, 1'b0, 2'd2, 16'hFFFF, 1'b1, 16'h0000, 1'b1);
        chk("t2 reg2", 64'(reg_q[47:32]), 64'h1234);
        chk("t2 viol_count", 64'(viol_count), 64'd1);

        // 3: scan and debug do not open a lock; scan hides locked reads
        scan_mode = 1'b1;
        debug_unlocked = 1'b1;
        access("t3 scanwr", 0, 1'b1, 1'b0, 2'd2, 16'hBEEF, 1'b1, 16'h0000, 1'b1);
        chk("t3 reg2", 64'(reg_q[47:32]), 64'h1234);
        chk("t3 viol_count", 64'(viol_count), 64'd2);
        access("t3 rd_hidden", 1, 1'b0, 1'b0, 2'd2, 16'h0000, 1'b1, 16'h0000, 1'b0);
        access("t3 rd_open", 0, 1'b0, 1'b0, 2'd1, 16'h0000, 1'b0, 16'hA5A5, 1'b0);
        access("t3 scan_unlk", 0, 1'b1, 1'b0, 2'd3, 16'h7777, 1'b1, 16'h0000, 1'b1);
        chk("t3 reg3", 64'(reg_q[63:48]), 64'h0000);
        scan_mode = 1'b0;
        access("t3 dbgwr", 0, 1'b1, 1'b0, 2'd2, 16'h5555, 1'b1, 16'h0000, 1'b1);
        access("t3 relock", 1, 1'b1, 1'b1, 2'd2, 16'h6666, 1'b1, 16'h0000, 1'b1);
        chk("t3 viol_count", 64'(viol_count), 64'd5);
        chk("t3 reg2 final", 64'(reg_q[47:32]), 64'h1234);
        debug_unlocked = 1'b0;

        // 4: both requesters valid, grants must alternate 0,1,0,1
        set_req(0, 1'b0, 1'b0, 2'd1, 16'h0000);
        set_req(1, 1'b0, 1'b0, 2'd2, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            exp_g  = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_rd = (k % 2 == 0) ? 16'hA5A5 : 16'h1234;
            @(negedge clk); #1;
            t = 0;
            while (bus.req_ready == 2'b00 && t < 20) begin
                @(negedge clk); #1; t++;
            end
            chk("t4 grant", 64'(bus.req_ready), 64'(exp_g));
            chk("t4 wait", 64'(t), 64'd0);
            @(negedge clk);
            chk("t4 exec_rsp", 64'(bus.rsp_valid), 64'd0);
            @(negedge clk);
            chk("t4 rsp_valid", 64'(bus.rsp_valid), 64'(exp_g));
            chk("t4 rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
        end
        bus.req_valid = '0;

        // 5: saturate the violation counter
        set_req(0, 1'b1, 1'b0, 2'd2, 16'h0000);
        cnt = 0;
        cyc = 0;
        while (cnt < 300 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (bus.rsp_valid[0]) cnt++;
        end
        bus.req_valid = '0;
        chk("t5 rsp_count", 64'(cnt), 64'd300);
        chk("t5 viol_sat", 64'(viol_count), 64'd255);
        access("t5 past_sat", 0, 1'b1, 1'b0, 2'd2, 16'h0000, 1'b1, 16'h0000, 1'b1);
        chk("t5 viol_hold", 64'(viol_count), 64'd255);

        // 5b: reset in the middle of EXEC drops the access
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 2'd0, 16'h5555);
        #1;
        t = 0;
        while (bus.req_ready == 2'b00 && t < 20) begin
            @(negedge clk); #1; t++;
        end
        chk("t5 rst_ready", 64'(bus.req_ready), 64'h1);
        @(negedge clk);
        bus.req_valid = '0;
        resetn = 1'b0;
        #1;
        chk("t5 rst_lock", 64'(lock_status), 64'd0);
        chk("t5 rst_regq", reg_q, 64'd0);
        chk("t5 rst_count", 64'(viol_count), 64'd0);
        @(negedge clk);
        chk("t5 rst_norsp", 64'(bus.rsp_valid), 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("t5 post_norsp", 64'(bus.rsp_valid), 64'd0);
        chk("t5 post_regq", reg_q, 64'd0);

        // 6: scan entry with data loaded
        access("t6 wr3", 0, 1'b1, 1'b0, 2'd3, 16'hCAFE, 1'b0, 16'h0000, 1'b0);
        access("t6 lk0", 1, 1'b1, 1'b1, 2'd0, 16'h0F0F, 1'b0, 16'h0000, 1'b0);
        chk("t6 loaded", reg_q, 64'hCAFE_0000_0000_0F0F);
        @(negedge clk);
        scan_mode = 1'b1;
        repeat (3) @(negedge clk);
`ifdef LOCKREG_SCAN_CLEAR_EN
        chk("t6 scan_regq", reg_q, 64'd0);
`else
        chk("t6 scan_regq", reg_q, 64'hCAFE_0000_0000_0F0F);
`endif
        chk("t6 scan_lock", 64'(lock_status), 64'h1);
        scan_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
